// File: rtl/sp_gearbox_pkg.sv
// sp_gearbox_pkg: state encoding and count-width helper shared by the gearbox files.
package sp_gearbox_pkg;
  typedef enum logic {FILL, FULL} state_t;
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sp_gearbox_ctrl.sv
// sp_gearbox_ctrl: fill/full handshake state, word count and datapath shift/clear strobes.
module sp_gearbox_ctrl
  import sp_gearbox_pkg::*;
#(
  parameter int M = 2,
  localparam int CW = cnt_w(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          in_ready,
  output logic          out_valid,
  output logic          shift,
  output logic          clear,
  output logic [CW-1:0] cnt
);
  state_t state;
  logic [CW-1:0] cnt_acc;
  always_comb begin
    out_valid = state == FULL;
    in_ready  = !out_valid || out_ready;
    shift     = in_valid && in_ready;
    clear     = out_valid && out_ready;
    cnt_acc   = (clear ? '0 : cnt) + CW'(shift);
  end
  // cnt_acc already includes a same-cycle accept, so a flush alongside it still counts
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      cnt   <= cnt_acc;
      state <= (state == FULL) ? (clear ? FILL : FULL)
             : ((cnt_acc == CW'(M) || (flush && cnt_acc != '0)) ? FULL : FILL);
    end
  end
endmodule

// File: rtl/sp_gearbox.sv
// sp_gearbox: packs M N-bit words into one group with valid/ready on both sides.
// Optional flush of a partial group when SP_GEARBOX_FLUSH_EN is defined.
module sp_gearbox
  import sp_gearbox_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           sin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*N-1:0]         q,
  output logic [cnt_w(M)-1:0]    cnt
`ifdef SP_GEARBOX_FLUSH_EN
  ,
  input  logic                   flush
`endif
);
  logic shift, clear, fl;
  logic [M*N-1:0] base, nxt;
`ifdef SP_GEARBOX_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  sp_gearbox_ctrl #(.M(M)) u_ctrl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready), .flush(fl),
    .in_ready(in_ready), .out_valid(out_valid), .shift(shift), .clear(clear), .cnt(cnt)
  );
  // an emit clears the group first, so a concurrent accept starts a fresh one
  always_comb begin
    base = clear ? '0 : q;
    nxt  = (LSB_FIRST != 0) ? {sin, base[M*N-1:N]} : {base[(M-1)*N-1:0], sin};
  end
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (shift) q <= nxt;
    else if (clear) q <= '0;
  end
endmodule

// File: doc/sp_gearbox.md
SP_GEARBOX -- requirements
Module: sp_gearbox

Interface
REQ-001 Parameter N, default 4, bits per input word; SHALL be >= 1.
REQ-002 Parameter M, default 2, words per output group; SHALL be >= 2.
REQ-003 Parameter LSB_FIRST, default 0; 0 = first-accepted word in most significant slot, 1 = first-accepted word in least significant slot.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  sin carries a word.
REQ-007 in_ready  output  1  block accepts sin this cycle.
REQ-008 sin  input  N  input word.
REQ-009 out_valid  output  1  q holds a complete or flushed group.
REQ-010 out_ready  input  1  consumer takes q this cycle.
REQ-011 q  output  M*N  assembled group, driven directly from the data register.
REQ-012 cnt  output  $clog2(M+1)  number of valid words currently in q.
REQ-013 flush  input  1  emit partial group; present only when SP_GEARBOX_FLUSH_EN is defined.

Function
REQ-014 Accept = in_valid && in_ready; Emit = out_valid && out_ready.
REQ-015 States FILL (out_valid=0, in_ready=1) and FULL (out_valid=1, in_ready=out_ready).
REQ-016 On accept in FILL with LSB_FIRST=0: q <= {q[(M-1)*N-1:0], sin}; with LSB_FIRST=1: q <= {sin, q[M*N-1:N]}; cnt increments by 1.
REQ-017 Accept that makes cnt == M SHALL move FILL -> FULL; out_valid asserts on the following cycle (latency 1 cycle after the Mth accept).
REQ-018 In FULL without Emit, q, cnt and state SHALL hold; in_ready=0, so no word is lost.
REQ-019 Emit without Accept: q <= 0, cnt <= 0, state -> FILL.
REQ-020 Emit with simultaneous Accept: q <= zero register with sin shifted in per REQ-016, cnt <= 1, state -> FILL; no bubble, sustained throughput one word per cycle.
REQ-021 Unused slots of q SHALL always read zero (partial group: low cnt*N bits valid when LSB_FIRST=0, high cnt*N bits when LSB_FIRST=1).
REQ-022 sin and in_valid are ignored when in_ready=0.

Reset
REQ-023 reset SHALL force q=0, cnt=0, state FILL, out_valid=0, in_ready=1 on the next edge, overriding all other inputs.
REQ-024 reset mid-group or while FULL SHALL discard all buffered words; no partial group is emitted.

Configuration
REQ-025 Macro SP_GEARBOX_FLUSH_EN: when defined, flush port exists; flush in FILL with cnt > 0 (after including any same-cycle Accept) SHALL move to FULL with cnt and q unchanged apart from that Accept.
REQ-026 With SP_GEARBOX_FLUSH_EN: flush in FILL with cnt == 0 and no Accept SHALL have no effect; flush in FULL SHALL be ignored.
REQ-027 Without SP_GEARBOX_FLUSH_EN: no flush port; FULL is entered only when cnt reaches M.

Structure
REQ-028 Package sp_gearbox_pkg SHALL hold the state enum typedef (FILL, FULL) and a cnt-width helper function.
REQ-029 One sub-module sp_gearbox_ctrl SHALL hold state and cnt and generate in_ready/out_valid and shift/clear strobes; the datapath register stays in sp_gearbox.

Verification (N=4, M=2)
REQ-030 Reset, accept 0xA then 0xB, out_ready=0 -> out_valid=1 one cycle after 0xB accept, q=0xAB, cnt=2.
REQ-031 Hold FULL with out_ready=0, in_valid=1, sin=0xC -> in_ready=0, q stays 0xAB; then out_ready=1 -> 0xC accepted same cycle, next q=0x0C, cnt=1, out_valid=0.
REQ-032 in_valid=1 and out_ready=1 continuously, sin=1,2,3,4... -> out_valid on every second cycle, q=0x12, 0x34, ... with no dropped words.
REQ-033 LSB_FIRST=1, accept 0xA then 0xB -> q=0xBA; single 0x5 then flush -> q=0x50, cnt=1.
REQ-034 SP_GEARBOX_FLUSH_EN defined, LSB_FIRST=0, accept 0x5 then flush -> q=0x05, cnt=1, out_valid=1; flush with cnt=0 -> out_valid stays 0.
REQ-035 Accept 0x7, assert reset next cycle -> q=0, cnt=0, out_valid=0; then 0x1, 0x2 -> q=0x12.
